// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: streaming RV32I instruction encoder.
// Symbolic ops are accepted over valid/ready and encoded into a register stage.
// The encoded words then pass through a small FIFO and are written to
// consecutive imem word addresses through a stallable write port.
// Optional build macro IMM_RANGE_CHECK_EN: ops whose immediate does not fit
// its field (or is odd for a branch or jump) are dropped and raise err.
// Without the macro, immediates are truncated to their field.
module rv_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              err_q;
  logic              wrap_q;

  logic [31:0]       enc_next;
  logic              op_legal;
  logic              imm_ok;
  logic              enc_ok;
  logic              enc_valid;
  logic [31:0]       enc_word;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    pending;

  logic              accept;
  logic              pop;

  // Words in flight include the one in the encode register, so the FIFO can never overflow.
  assign pending  = count + {{PTR_W{1'b0}}, enc_valid};
  assign in_ready = (state == STREAM) && (pending < DEPTH_CNT);
  assign accept   = in_valid && in_ready;
  assign imem_we  = (count != '0);
  assign pop      = imem_we && imem_ready;

  // Pack the symbolic op into its RV32I bit layout; unused register fields stay zero.
  always_comb begin
    enc_next = '0;
    op_legal = 1'b1;
    case (in_op)
      4'd0:  enc_next = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd1:  enc_next = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd2:  enc_next = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
      4'd3:  enc_next = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
      4'd4:  enc_next = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
      4'd5:  enc_next = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_I};
      4'd6:  enc_next = {in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_I};
      4'd7:  enc_next = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      4'd8:  enc_next = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      4'd9:  enc_next = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], OPC_BRANCH};
      4'd10: enc_next = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                         in_imm[4:1], in_imm[11], OPC_BRANCH};
      4'd11: enc_next = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      4'd12: enc_next = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      default: op_legal = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic fits_i;
  logic fits_b;
  logic fits_j;

  // An immediate fits when every bit above the field's sign bit copies the sign.
  assign fits_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_b = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign fits_j = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  // Select the range test that matches the op's immediate format.
  always_comb begin
    imm_ok = 1'b1;
    case (in_op)
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12: imm_ok = fits_i;
      4'd9, 4'd10:                         imm_ok = fits_b;
      4'd11:                               imm_ok = fits_j;
      default:                             imm_ok = 1'b1;
    endcase
  end
`else
  logic imm_unused;

  assign imm_ok     = 1'b1;
  assign imm_unused = ^in_imm[31:21];
`endif

  assign enc_ok = op_legal & imm_ok;

  // Encode register: a legal accepted op lands here one cycle before it enters the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_valid <= 1'b0;
      enc_word  <= '0;
    end else begin
      enc_valid <= accept & enc_ok;
      if (accept & enc_ok) enc_word <= enc_next;
    end
  end

  // FIFO storage: no reset is needed because the output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (enc_valid) mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers and occupancy; reset throws away any queued words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enc_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({enc_valid, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Session control plus the address counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (pop) begin
        addr <= addr + 1'b1;
        if (&addr) wrap_q <= 1'b1;
      end
      if (accept && !enc_ok) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= STREAM;
            addr   <= base_addr;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
          end
        end
        STREAM: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if ((count == '0) && !enc_valid) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_addr  = addr;
  assign imem_wdata = imem_we ? mem[rd_ptr] : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: self-checking bench for rv_instr_encoder.
// The fixed vectors come from a table of hand-encoded words. The random
// sessions use a field-placement model of the RV32I formats. A queue
// scoreboard checks every imem write for address and data.
module tb_rv_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic              imem_ready = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              wrap;

  rv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } exp_t;

  vec_t       vecs [10];
  exp_t       expq [$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_addr = '0;
  logic       exp_err = 1'b0;
  logic       exp_wrap = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int unsigned fld(input logic [31:0] v, input int hi, input int lo);
    int unsigned x;
    x = v;
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: adds each field, shifted to its bit position.
  function automatic bit model_encode(input vec_t v, output logic [31:0] w);
    int unsigned rdv, rs1v, rs2v, f3, f7, x;
    bit ok;
`ifdef IMM_RANGE_CHECK_EN
    int s;
`endif
    rdv  = {27'd0, v.rd};
    rs1v = {27'd0, v.rs1};
    rs2v = {27'd0, v.rs2};
    ok = 1'b1;
    x = 0;
    f3 = 0;
    f7 = 0;
    case (v.op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        f3 = (v.op == 4'd2) ? 6 : (v.op == 4'd3) ? 7 : 0;
        f7 = (v.op == 4'd1) ? 32 : 0;
        x = 'h33 + (rdv << 7) + (f3 << 12) + (rs1v << 15) + (rs2v << 20) + (f7 << 25);
      end
      4'd4, 4'd5, 4'd6: begin
        f3 = (v.op == 4'd4) ? 0 : (v.op == 4'd5) ? 6 : 7;
        x = 'h13 + (rdv << 7) + (f3 << 12) + (rs1v << 15) + (fld(v.imm, 11, 0) << 20);
      end
      4'd7:  x = 'h03 + (rdv << 7) + (2 << 12) + (rs1v << 15) + (fld(v.imm, 11, 0) << 20);
      4'd8:  x = 'h23 + (fld(v.imm, 4, 0) << 7) + (2 << 12) + (rs1v << 15) + (rs2v << 20)
               + (fld(v.imm, 11, 5) << 25);
      4'd9, 4'd10: begin
        f3 = (v.op == 4'd10) ? 1 : 0;
        x = 'h63 + (fld(v.imm, 11, 11) << 7) + (fld(v.imm, 4, 1) << 8) + (f3 << 12)
          + (rs1v << 15) + (rs2v << 20) + (fld(v.imm, 10, 5) << 25) + (fld(v.imm, 12, 12) << 31);
      end
      4'd11: x = 'h6F + (rdv << 7) + (fld(v.imm, 19, 12) << 12) + (fld(v.imm, 11, 11) << 20)
               + (fld(v.imm, 10, 1) << 21) + (fld(v.imm, 20, 20) << 31);
      4'd12: x = 'h67 + (rdv << 7) + (rs1v << 15) + (fld(v.imm, 11, 0) << 20);
      default: ok = 1'b0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    s = v.imm;
    case (v.op)
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12: if (s < -2048 || s > 2047) ok = 1'b0;
      4'd9, 4'd10: if (s < -4096 || s > 4095 || (s % 2) != 0) ok = 1'b0;
      4'd11: if (s < -(1 << 20) || s > (1 << 20) - 1 || (s % 2) != 0) ok = 1'b0;
      default: ;
    endcase
`endif
    w = x;
    return ok;
  endfunction

  task automatic push_expected(input logic [31:0] w);
    exp_t e;
    e.addr = exp_addr;
    e.word = w;
    expq.push_back(e);
    if (exp_addr == 8'hFF) exp_wrap = 1'b1;
    exp_addr = exp_addr + 8'd1;
  endtask

  // Write monitor: called on each falling edge, when a write will commit at the next rising edge.
  task automatic checkWrites();
    exp_t e;
    if (imem_we && imem_ready) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_write", {31'd0, imem_we}, 32'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
        checkOutput("wr_data", imem_wdata, e.word);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    checkWrites();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (rand_ready) imem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic doStart(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    step();
    start = 1'b0;
    exp_addr = base;
    exp_err = 1'b0;
    exp_wrap = 1'b0;
    sample();
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("err_cleared", {31'd0, err}, 32'd0);
    checkOutput("wrap_cleared", {31'd0, wrap}, 32'd0);
    advance();
  endtask

  // Hold one op on the input until the handshake completes, then record what it should produce.
  task automatic applyStimulus(input vec_t v, input bit last, input bit wr, input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    in_op = v.op;
    in_rd = v.rd;
    in_rs1 = v.rs1;
    in_rs2 = v.rs2;
    in_imm = v.imm;
    in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      sample();
      acc = in_ready;
      advance();
      if (acc) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
    else if (wr) push_expected(w);
    else exp_err = 1'b1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      sample();
      if (done) begin
        seen = 1'b1;
        checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
      end
      advance();
    end
    if (!seen) begin
      checkOutput("done_timeout", {31'd0, done}, 32'd1);
    end else begin
      sample();
      checkOutput("done_pulse", {31'd0, done}, 32'd0);
      checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
      checkOutput("err_end", {31'd0, err}, {31'd0, exp_err});
      checkOutput("wrap_end", {31'd0, wrap}, {31'd0, exp_wrap});
      checkOutput("queue_drained", 32'(expq.size()), 32'd0);
      advance();
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] w;
    bit          legal;
    int          n;

    vecs[0] = '{4'd0,  5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3};
    vecs[1] = '{4'd1,  5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3};
    vecs[2] = '{4'd4,  5'd5, 5'd0, 5'd0, 32'd10,        32'h00A00293};
    vecs[3] = '{4'd7,  5'd6, 5'd2, 5'd0, 32'd8,         32'h00812303};
    vecs[4] = '{4'd8,  5'd0, 5'd2, 5'd6, 32'd12,        32'h00612623};
    vecs[5] = '{4'd9,  5'd0, 5'd1, 5'd2, 32'd8,         32'h00208463};
    vecs[6] = '{4'd2,  5'd7, 5'd3, 5'd4, 32'd0,         32'h0041E3B3};
    vecs[7] = '{4'd3,  5'd8, 5'd5, 5'd6, 32'd0,         32'h0062F433};
    vecs[8] = '{4'd11, 5'd1, 5'd0, 5'd0, 32'd16,        32'h010000EF};
    vecs[9] = '{4'd10, 5'd0, 5'd5, 5'd0, 32'hFFFFFFFC,  32'hFE029EE3};

    // Reset state.
    repeat (3) step();
    sample();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_wrap", {31'd0, wrap}, 32'd0);
    checkOutput("rst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_addr", {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    advance();
    rst_n = 1'b1;
    step();

    // First session: two-cycle latency of the first word, then the table rows.
    imem_ready = 1'b1;
    doStart(8'h10);
    applyStimulus(vecs[0], 1'b0, 1'b1, vecs[0].word);
    sample();
    checkOutput("lat_we_cycle1", {31'd0, imem_we}, 32'd0);
    advance();
    sample();
    checkOutput("lat_we_cycle2", {31'd0, imem_we}, 32'd1);
    checkOutput("lat_addr", {24'd0, imem_addr}, 32'h10);
    checkOutput("lat_data", imem_wdata, 32'h002081B3);
    advance();
    for (int i = 1; i <= 3; i++) applyStimulus(vecs[i], (i == 3), 1'b1, vecs[i].word);
    wait_done();

    // Write port stalled: the FIFO fills, back-pressure appears, and the head stays stable.
    imem_ready = 1'b0;
    doStart(8'h40);
    for (int i = 4; i <= 7; i++) applyStimulus(vecs[i], 1'b0, 1'b1, vecs[i].word);
    for (int i = 0; i < 6; i++) begin
      sample();
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_we", {31'd0, imem_we}, 32'd1);
      checkOutput("stall_addr", {24'd0, imem_addr}, 32'h40);
      checkOutput("stall_data", imem_wdata, 32'h00612623);
      advance();
    end
    imem_ready = 1'b1;
    applyStimulus(vecs[8], 1'b1, 1'b1, vecs[8].word);
    wait_done();

    // Address wrap from 0xFF to 0x00.
    doStart(8'hFE);
    applyStimulus(vecs[9], 1'b0, 1'b1, vecs[9].word);
    applyStimulus(vecs[2], 1'b0, 1'b1, vecs[2].word);
    applyStimulus(vecs[3], 1'b1, 1'b1, vecs[3].word);
    wait_done();

    // Illegal op carrying the last flag: no write, err set.
    doStart(8'h20);
    v = '{4'd14, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0};
    applyStimulus(v, 1'b1, 1'b0, 32'd0);
    wait_done();

    // Oversized ADDI immediate: dropped with range checking, truncated without it.
    doStart(8'h24);
    v = '{4'd4, 5'd5, 5'd0, 5'd0, 32'd4096, 32'd0};
    legal = model_encode(v, w);
    applyStimulus(v, 1'b1, legal, w);
    wait_done();

    // Reset with words queued, followed by a clean session.
    imem_ready = 1'b0;
    doStart(8'h30);
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], 1'b0, 1'b1, vecs[i].word);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("arst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("arst_addr", {24'd0, imem_addr}, 32'd0);
    expq.delete();
    step();
    rst_n = 1'b1;
    step();
    imem_ready = 1'b1;
    doStart(8'h50);
    applyStimulus(vecs[0], 1'b1, 1'b1, vecs[0].word);
    wait_done();

    // Random sessions against the reference model, with random write stalls and ignored starts.
    rand_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      doStart(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) step();
        if (k == 1 && (s % 2) == 0) begin
          start = 1'b1;
          base_addr = 8'($urandom_range(0, 255));
          step();
          start = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) v.op = 4'($urandom_range(13, 15));
        else v.op = 4'($urandom_range(0, 12));
        v.rd = 5'($urandom_range(0, 31));
        v.rs1 = 5'($urandom_range(0, 31));
        v.rs2 = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 2))
          0: v.imm = $urandom;
          1: v.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
          default: v.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        endcase
        v.word = '0;
        legal = model_encode(v, w);
        applyStimulus(v, (k == n - 1), legal, w);
      end
      wait_done();
    end
    rand_ready = 1'b0;
    imem_ready = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
